// File: rtl/div_share_ctrl.sv
// Two-port round-robin controller around a shared repeated-subtraction divider.
// Results come back on a shared bus, qualified by a one-cycle per-port ack.
module div_share_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic             owner_nxt;
  logic [WIDTH-1:0] rem_r, rem_nxt;
  logic [WIDTH-1:0] div_r, div_nxt;
  logic [WIDTH-1:0] quo_r, quo_nxt;
  logic             err_r, err_r_nxt;
  logic             ack0_nxt, ack1_nxt;
  logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
  logic             err_nxt, busy_nxt;

  // Arbitration and operand select; a tie goes to the port that was not served last
  logic             req_any_c;
  logic             gnt_port_c;
  logic [WIDTH-1:0] sel_x_c, sel_y_c;
  logic             rem_ge_c;
  logic [WIDTH-1:0] rem_diff_c;

  always_comb begin
    req_any_c  = req0 | req1;
    gnt_port_c = (req0 && req1) ? ~last : req1;
    sel_x_c    = gnt_port_c ? x1 : x0;
    sel_y_c    = gnt_port_c ? y1 : y0;
    rem_ge_c   = (rem_r >= div_r);
    rem_diff_c = rem_r - div_r;
  end

  // Next-state, datapath and output computation
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    owner_nxt     = owner;
    rem_nxt       = rem_r;
    div_nxt       = div_r;
    quo_nxt       = quo_r;
    err_r_nxt     = err_r;
    ack0_nxt      = 1'b0;
    ack1_nxt      = 1'b0;
    err_nxt       = 1'b0;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;

    case (state)
      IDLE: begin
        if (req_any_c) begin
          owner_nxt = gnt_port_c;
          rem_nxt   = sel_x_c;
          div_nxt   = sel_y_c;
          quo_nxt   = '0;
          if (sel_y_c == '0) begin
            err_r_nxt = 1'b1;
            state_nxt = DONE;
          end else begin
            err_r_nxt = 1'b0;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (rem_ge_c) begin
          rem_nxt = rem_diff_c;
          quo_nxt = quo_r + WIDTH'(1);
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Result bus and ack are loaded on the edge into DONE so they line up with it
    if (state_nxt == DONE) begin
      ack0_nxt      = ~owner_nxt;
      ack1_nxt      = owner_nxt;
      err_nxt       = err_r_nxt;
      quotient_nxt  = err_r_nxt ? {WIDTH{1'b1}} : quo_nxt;
      remainder_nxt = rem_nxt;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      rem_r     <= '0;
      div_r     <= '0;
      quo_r     <= '0;
      err_r     <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      owner     <= owner_nxt;
      rem_r     <= rem_nxt;
      div_r     <= div_nxt;
      quo_r     <= quo_nxt;
      err_r     <= err_r_nxt;
      ack0      <= ack0_nxt;
      ack1      <= ack1_nxt;
      err       <= err_nxt;
      busy      <= busy_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: directed jobs push expected results,
// a negedge monitor pops and compares on every ack.
module tb_div_share_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic             ack0, ack1, err, busy, owner;
  logic [WIDTH-1:0] quotient, remainder;

  typedef struct packed {
    logic             port;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   lat[4];

  div_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .x0(x0), .y0(y0),
    .req1(req1), .x1(x1), .y1(y1),
    .ack0(ack0), .ack1(ack1),
    .quotient(quotient), .remainder(remainder),
    .err(err), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Push the expected result and raise the request with its operands
  task automatic start(input logic port, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic e);
    exp_t t;
    t.port = port; t.q = q; t.r = r; t.e = e;
    sb.push_back(t);
    if (port) begin
      x1 = x; y1 = y; req1 = 1'b1;
    end else begin
      x0 = x; y0 = y; req0 = 1'b1;
    end
  endtask

  // Count negedges until n acks are seen; lat[i] is the cycle index of ack i
  task automatic wait_acks(input int n, input bit hold, input int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
        lat[seen] = cyc;
        seen++;
        if (!hold) begin
          if (ack0) req0 = 1'b0;
          if (ack1) req1 = 1'b0;
        end
      end
    end
    if (hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL wait_acks: timeout, saw %0d of %0d acks", seen, n);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head
  always @(negedge clk) begin
    exp_t got;
    if (ack0 || ack1) begin
      check("ack_onehot", 32'(ack0 & ack1), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d expected none", ack0, ack1);
      end else begin
        got = sb.pop_front();
        check("ack_port",  32'(ack1),      32'(got.port));
        check("owner",     32'(owner),     32'(got.port));
        check("quotient",  32'(quotient),  32'(got.q));
        check("remainder", 32'(remainder), 32'(got.r));
        check("err",       32'(err),       32'(got.e));
        check("busy_done", 32'(busy),      32'd1);
      end
    end
  end

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #12;
    check("rst_ack0",      32'(ack0),      32'd0);
    check("rst_ack1",      32'(ack1),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_quotient",  32'(quotient),  32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_owner",     32'(owner),     32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Tie from reset, both held: order 0,1,0,1
    @(negedge clk);
    start(1'b0, 16'd100, 16'd10, 16'd10, 16'd0, 1'b0);
    start(1'b1, 16'd50,  16'd7,  16'd7,  16'd1, 1'b0);
    start(1'b0, 16'd100, 16'd10, 16'd10, 16'd0, 1'b0);
    start(1'b1, 16'd50,  16'd7,  16'd7,  16'd1, 1'b0);
    wait_acks(4, 1'b1, 200);
    check("lat_tie0", 32'(lat[0]), 32'd12);
    check("lat_tie1", 32'(lat[1]), 32'd22);
    check("lat_tie3", 32'(lat[3]), 32'd45);

    // Single job on port 0
    @(negedge clk);
    start(1'b0, 16'd123, 16'd11, 16'd11, 16'd2, 1'b0);
    wait_acks(1, 1'b0, 100);
    check("lat_123_11", 32'(lat[0]), 32'd13);

    // x<y and x==y on port 1
    @(negedge clk);
    start(1'b1, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
    wait_acks(1, 1'b0, 100);
    check("lat_5_9", 32'(lat[0]), 32'd2);
    @(negedge clk);
    start(1'b1, 16'd7, 16'd7, 16'd1, 16'd0, 1'b0);
    wait_acks(1, 1'b0, 100);
    check("lat_7_7", 32'(lat[0]), 32'd3);

    // Divide by zero, then a normal job clears err
    @(negedge clk);
    start(1'b0, 16'd40, 16'd0, 16'hFFFF, 16'd40, 1'b1);
    wait_acks(1, 1'b0, 100);
    check("lat_div0", 32'(lat[0]), 32'd1);
    @(negedge clk);
    start(1'b0, 16'd40, 16'd8, 16'd5, 16'd0, 1'b0);
    wait_acks(1, 1'b0, 100);
    check("lat_40_8", 32'(lat[0]), 32'd7);

    // Reset mid-RUN: job abandoned, outputs clear asynchronously
    @(negedge clk);
    x0 = 16'd60000; y0 = 16'd3; req0 = 1'b1;
    repeat (20) @(negedge clk);
    check("busy_mid_run", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_ack0",      32'(ack0),      32'd0);
    check("arst_quotient",  32'(quotient),  32'd0);
    check("arst_remainder", 32'(remainder), 32'd0);
    check("arst_owner",     32'(owner),     32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // last was 0 before reset; port 0 still wins the tie after it
    @(negedge clk);
    start(1'b0, 16'd9, 16'd4, 16'd2, 16'd1, 1'b0);
    start(1'b1, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);
    wait_acks(2, 1'b0, 100);
    check("lat_9_4", 32'(lat[0]), 32'd4);
    check("lat_9_3", 32'(lat[1]), 32'd10);

    // Worst case with a port 1 request arriving mid-job
    @(negedge clk);
    start(1'b0, 16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0);
    repeat (100) @(negedge clk);
    start(1'b1, 16'd20, 16'd6, 16'd3, 16'd2, 1'b0);
    wait_acks(2, 1'b0, 70000);
    check("lat_worst",   32'(lat[0]), 32'd65437);
    check("lat_waiting", 32'(lat[1]), 32'd65443);

    // Result bus holds after DONE
    @(negedge clk);
    check("hold_quotient",  32'(quotient),  32'd3);
    check("hold_remainder", 32'(remainder), 32'd2);
    check("idle_busy",      32'(busy),      32'd0);
    check("sb_empty",       32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Controller that shares one 16-bit repeated-subtraction divide datapath between two requesters (port 0, port 1).
- Round-robin arbitration between the two requesters.
- Sequences load, iterate and complete, and returns quotient, remainder and divide-by-zero status with a per-port ack pulse.
- Sits between the two client blocks and the subtract/compare datapath; the datapath registers and subtract are instantiated inside this block.

Parameters:
- WIDTH, 16, operand/quotient/remainder width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 divide request; level, sampled only in IDLE.
- x0  input  WIDTH  port 0 dividend; valid while req0 high.
- y0  input  WIDTH  port 0 divisor; valid while req0 high.
- req1  input  1  port 1 divide request.
- x1  input  WIDTH  port 1 dividend.
- y1  input  WIDTH  port 1 divisor.
- ack0  output  1  one-cycle pulse; port 0 result valid this cycle.
- ack1  output  1  one-cycle pulse; port 1 result valid this cycle.
- quotient  output  WIDTH  shared result bus; quotient of the completed job.
- remainder  output  WIDTH  shared result bus; remainder of the completed job.
- err  output  1  high with ack when the divisor was 0.
- busy  output  1  high in RUN and DONE.
- owner  output  1  port index of the current or most recent job.

Behaviour:
- Reset (reset low, async), required values:
  - state = IDLE.
  - ack0, ack1, err, busy = 0.
  - quotient, remainder = 0.
  - owner = 0.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - A job in flight is abandoned; no ack is issued for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requests: grant the port != last.
  - On the grant edge:
    - owner <= granted port.
    - Latch x into rem_r and y into div_r.
    - quo_r <= 0.
    - If y == 0: err_r <= 1, go to DONE.
    - Otherwise: err_r <= 0, go to RUN.
- RUN: one compare and subtract per cycle, unsigned.
  - If rem_r >= div_r: rem_r <= rem_r - div_r, quo_r <= quo_r + 1, stay in RUN.
  - Else: go to DONE.
- DONE (exactly one cycle):
  - ack[owner] = 1.
  - quotient = quo_r, remainder = rem_r, err = err_r.
  - last <= owner.
  - Next state IDLE.
- Result hold and error values:
  - quotient and remainder hold their values after DONE until the next DONE.
  - On a divide-by-zero job: quotient = all-ones (16'hFFFF), remainder = x.
- Latency: with the grant at edge 0, ack is high in the cycle after edge q+1 (q = x/y).
  - y==0: ack is high in the cycle after edge 0.
  - Worst case x=65535, y=1: 65536 cycles.
- Requester handshake:
  - A requester keeps req and its operands stable until its ack.
  - Operands are latched at grant, so changes after the grant edge do not affect the job.
  - A req still high in the IDLE cycle after ack is treated as a new job.
- A request from the non-owner during RUN/DONE is not lost: it is held by level and granted in the next IDLE.
  - Because last was updated, the waiting port wins any tie.
- Arithmetic is unsigned; the quotient cannot overflow WIDTH because q <= x.
- ack0 and ack1 are never high in the same cycle.
- busy = 1 exactly in RUN and DONE.
- Reset asserted mid-RUN:
  - All outputs return to reset values immediately (async).
  - After release, the first IDLE re-arbitrates from last = 1.

Test Plan:
- Single job, port 0: x0=123, y0=11 -> ack0 at grant+13 cycles; quotient=11, remainder=2, err=0, owner=0; ack1 never high.
- x<y, port 1: x1=5, y1=9 -> ack1 at grant+2; quotient=0, remainder=5. Also x1=y1=7 -> quotient=1, remainder=0.
- Divide by zero, port 0: x0=40, y0=0 -> ack0 in the cycle after grant; err=1, quotient=16'hFFFF, remainder=40. The next job (40/8) gives err=0, quotient=5, remainder=0.
- Simultaneous requests, both held high: port0 100/10 and port1 50/7 from reset:
  - Port 0 is served first: quotient=10, remainder=0.
  - Then port 1: quotient=7, remainder=1.
  - With both re-requesting, the order alternates 0,1,0,1 over 4 jobs.
- Reset mid-RUN: start 60000/3, assert reset 20 cycles later -> busy, ack0, quotient, remainder drop to 0 asynchronously. After release, 9/4 gives quotient=2, remainder=1 with normal latency.
- Worst case: 65535/1 -> ack after 65536 cycles; quotient=65535, remainder=0. A port 1 request arriving mid-job is granted in the following IDLE.
